// File: rtl/sigmacore_pkg.sv
// sigmacore_pkg: shared types and constants for the SigmaCore memory arbiter
package sigmacore_pkg;

    localparam int XLEN     = 32;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;

endpackage

// File: rtl/sigmacore_arb_fairness.sv
// sigmacore_arb_fairness: LS-priority winner select with a bounded LS streak that guarantees fetch progress
module sigmacore_arb_fairness
    import sigmacore_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       if_req_i,
    input  logic       ls_req_i,
    input  logic       grant_en_i,
    output arb_owner_t owner_o,
    output logic       valid_o
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                force_if;

    assign force_if = if_req_i && (streak_q == MAX_S);
    assign valid_o  = grant_en_i && (if_req_i || ls_req_i);
    assign owner_o  = (ls_req_i && !force_if) ? OWN_LS : OWN_IF;
    assign streak_d = (!if_req_i || owner_o == OWN_IF) ? '0 :
                      (streak_q == MAX_S) ? streak_q : streak_q + 1'b1;

    // Streak only moves on arbitration cycles; an idle fetcher or an IF win resets it
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) streak_q <= '0;
        else if (grant_en_i) streak_q <= streak_d;
    end

endmodule

// File: rtl/sigmacore_mem_arbiter.sv
// sigmacore_mem_arbiter: shares one single-port memory between fetch and load/store; optional counters under SIGMA_ARB_PERF_EN
module sigmacore_mem_arbiter
    import sigmacore_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [3:0]      ls_be_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ready_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
`ifdef SIGMA_ARB_PERF_EN
    output logic [31:0]     perf_if_grants_o,
    output logic [31:0]     perf_ls_grants_o,
    output logic [31:0]     perf_stall_cycles_o,
`endif
    output logic            proto_err_o
);

    arb_state_t      state_q;
    arb_owner_t      owner_q;
    arb_owner_t      win_owner;
    logic            win_valid;
    logic            grant_en;
    logic            resp;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [3:0]      mem_be_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            proto_err_q;

    // Gating with reset keeps the combinational grants low while reset is asserted
    assign grant_en = reset_n_i && (state_q == ARB_IDLE);

    sigmacore_arb_fairness #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_fair (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .if_req_i  (if_req_i),
        .ls_req_i  (ls_req_i),
        .grant_en_i(grant_en),
        .owner_o   (win_owner),
        .valid_o   (win_valid)
    );

    assign if_gnt_o    = win_valid && (win_owner == OWN_IF);
    assign ls_gnt_o    = win_valid && (win_owner == OWN_LS);
    assign resp        = (state_q == ARB_WAIT_RESP) && mem_rvalid_i;
    assign if_rvalid_o = resp && (owner_q == OWN_IF);
    assign ls_rvalid_o = resp && (owner_q == OWN_LS);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign proto_err_o = proto_err_q;

    // Transaction FSM: latch the winner's request, hold it until accepted, then wait for the response
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (mem_rvalid_i && state_q != ARB_WAIT_RESP) proto_err_q <= 1'b1;
            case (state_q)
                ARB_IDLE: if (win_valid) begin
                    owner_q     <= win_owner;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= (win_owner == OWN_LS) && ls_we_i;
                    mem_be_q    <= (win_owner == OWN_LS) ? ls_be_i : 4'hF;
                    mem_addr_q  <= (win_owner == OWN_LS) ? ls_addr_i : if_addr_i;
                    mem_wdata_q <= (win_owner == OWN_LS) ? ls_wdata_i : '0;
                    state_q     <= ARB_ISSUE;
                end
                ARB_ISSUE: if (mem_ready_i) begin
                    mem_req_q <= 1'b0;
                    state_q   <= ARB_WAIT_RESP;
                end
                ARB_WAIT_RESP: if (mem_rvalid_i) state_q <= ARB_IDLE;
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

`ifdef SIGMA_ARB_PERF_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_ls_q;
    logic [31:0] perf_stall_q;

    assign perf_if_grants_o    = perf_if_q;
    assign perf_ls_grants_o    = perf_ls_q;
    assign perf_stall_cycles_o = perf_stall_q;

    // Free-running wrap-around counters of grants and of cycles where someone waits
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_if_q    <= '0;
            perf_ls_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_if_q    <= perf_if_q + {31'd0, if_gnt_o};
            perf_ls_q    <= perf_ls_q + {31'd0, ls_gnt_o};
            perf_stall_q <= perf_stall_q + {31'd0, (if_req_i && !if_gnt_o) || (ls_req_i && !ls_gnt_o)};
        end
    end
`endif

endmodule

// File: tb/tb_sigmacore_mem_arbiter.sv
// tb_sigmacore_mem_arbiter: directed self-checking bench for the fetch/LSU memory arbiter
module tb_sigmacore_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        proto_err;
`ifdef SIGMA_ARB_PERF_EN
    logic [31:0] perf_if;
    logic [31:0] perf_ls;
    logic [31:0] perf_stall;
    logic [31:0] perf_if0;
    logic [31:0] perf_ls0;
`endif

    int errors = 0;
    int checks = 0;
    logic exp_if;

    always #5 clk = ~clk;

    sigmacore_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .ls_req_i    (ls_req),
        .ls_we_i     (ls_we),
        .ls_be_i     (ls_be),
        .ls_addr_i   (ls_addr),
        .ls_wdata_i  (ls_wdata),
        .ls_gnt_o    (ls_gnt),
        .ls_rvalid_o (ls_rvalid),
        .ls_rdata_o  (ls_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (mem_ready),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
`ifdef SIGMA_ARB_PERF_EN
        .perf_if_grants_o   (perf_if),
        .perf_ls_grants_o   (perf_ls),
        .perf_stall_cycles_o(perf_stall),
`endif
        .proto_err_o (proto_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks follow 1 unit later
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_proto_err", proto_err, 1'b0);
        // Scenario 1: single fetch at minimum latency
        tick;
        reset_n = 1'b1;
        #1;
        chk1("s1_if_gnt_c0", if_gnt, 1'b1);
        chk1("s1_ls_gnt_c0", ls_gnt, 1'b0);
        chk1("s1_mem_req_c0", mem_req, 1'b0);
        tick;
        if_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk1("s1_mem_req_c1", mem_req, 1'b1);
        chk1("s1_mem_we_c1", mem_we, 1'b0);
        chk32("s1_mem_be_c1", {28'd0, mem_be}, 32'hF);
        chk32("s1_mem_addr_c1", mem_addr, 32'h0);
        chk1("s1_if_gnt_c1", if_gnt, 1'b0);
        tick;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500293;
        #1;
        chk1("s1_mem_req_c2", mem_req, 1'b0);
        chk1("s1_if_rvalid_c2", if_rvalid, 1'b1);
        chk32("s1_if_rdata_c2", if_rdata, 32'h00500293);
        chk1("s1_ls_rvalid_c2", ls_rvalid, 1'b0);
        chk32("s1_ls_rdata_c2", ls_rdata, 32'h0);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk1("s1_if_rvalid_c3", if_rvalid, 1'b0);
        // Scenario 2: store
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h10000FF8; ls_wdata = 32'h20002123;
        #1;
        chk1("s2_ls_gnt", ls_gnt, 1'b1);
        chk1("s2_if_gnt", if_gnt, 1'b0);
        tick;
        ls_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk1("s2_mem_req", mem_req, 1'b1);
        chk1("s2_mem_we", mem_we, 1'b1);
        chk32("s2_mem_be", {28'd0, mem_be}, 32'hF);
        chk32("s2_mem_addr", mem_addr, 32'h10000FF8);
        chk32("s2_mem_wdata", mem_wdata, 32'h20002123);
        tick;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        #1;
        chk1("s2_ls_rvalid", ls_rvalid, 1'b1);
        chk1("s2_if_rvalid", if_rvalid, 1'b0);
        tick;
        mem_rvalid = 1'b0;
        // Scenario 3: both requesters held; expect LS,LS,LS,LS,IF twice
        if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80; mem_ready = 1'b1;
`ifdef SIGMA_ARB_PERF_EN
        perf_if0 = perf_if; perf_ls0 = perf_ls;
`endif
        for (int g = 0; g < 10; g++) begin
            exp_if = (g % 5 == 4);
            #1;
            chk1($sformatf("s3_if_gnt_%0d", g), if_gnt, exp_if);
            chk1($sformatf("s3_ls_gnt_%0d", g), ls_gnt, !exp_if);
            tick;
            #1;
            chk32($sformatf("s3_mem_addr_%0d", g), mem_addr, exp_if ? 32'h40 : 32'h80);
            tick;
            mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(g);
            #1;
            chk1($sformatf("s3_if_rvalid_%0d", g), if_rvalid, exp_if);
            chk1($sformatf("s3_ls_rvalid_%0d", g), ls_rvalid, !exp_if);
            tick;
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
`ifdef SIGMA_ARB_PERF_EN
        chk32("s3_perf_ls", perf_ls - perf_ls0, 32'd8);
        chk32("s3_perf_if", perf_if - perf_if0, 32'd2);
`endif
        // Scenario 4: mem_ready low for three ISSUE cycles while LS waits
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk1("s4_if_gnt", if_gnt, 1'b1);
        tick;
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h200;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk1($sformatf("s4_mem_req_%0d", s), mem_req, 1'b1);
            chk32($sformatf("s4_mem_addr_%0d", s), mem_addr, 32'h100);
            chk1($sformatf("s4_mem_we_%0d", s), mem_we, 1'b0);
            chk1($sformatf("s4_ls_gnt_%0d", s), ls_gnt, 1'b0);
            if (s < 2) tick;
        end
        mem_ready = 1'b1;
        tick;
        ls_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        chk1("s4_mem_req_done", mem_req, 1'b0);
        chk1("s4_if_rvalid", if_rvalid, 1'b1);
        chk32("s4_if_rdata", if_rdata, 32'hCAFEF00D);
        tick;
        mem_rvalid = 1'b0;
        // Scenario 5: reset while waiting for a load response
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
        #1;
        chk1("s5_ls_gnt", ls_gnt, 1'b1);
        tick;
        ls_req = 1'b0; mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        #1;
        chk1("s5_wait_mem_req", mem_req, 1'b0);
        chk32("s5_wait_mem_addr", mem_addr, 32'h300);
        reset_n = 1'b0;
        #1;
        chk32("s5_rst_mem_addr", mem_addr, 32'h0);
        chk32("s5_rst_mem_be", {28'd0, mem_be}, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        #1;
        chk1("s5_rst_ls_rvalid", ls_rvalid, 1'b0);
        chk32("s5_rst_ls_rdata", ls_rdata, 32'h0);
        tick;
        mem_rvalid = 1'b0; reset_n = 1'b1; if_req = 1'b1; if_addr = 32'h4;
        #1;
        chk1("s5_post_if_gnt", if_gnt, 1'b1);
        chk1("s5_post_proto_err", proto_err, 1'b0);
        tick;
        if_req = 1'b0; mem_ready = 1'b1;
        #1;
        chk32("s5_post_mem_addr", mem_addr, 32'h4);
        tick;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A00313;
        #1;
        chk1("s5_post_if_rvalid", if_rvalid, 1'b1);
        chk32("s5_post_if_rdata", if_rdata, 32'h00A00313);
        tick;
        mem_rvalid = 1'b0;
        // Scenario 6: stray memory response in IDLE
        #1;
        chk1("s6_pre_proto_err", proto_err, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #1;
        chk1("s6_if_rvalid", if_rvalid, 1'b0);
        chk1("s6_ls_rvalid", ls_rvalid, 1'b0);
        chk32("s6_if_rdata", if_rdata, 32'h0);
        tick;
        mem_rvalid = 1'b0;
        #1;
        chk1("s6_proto_err", proto_err, 1'b1);
        tick;
        tick;
        chk1("s6_proto_err_sticky", proto_err, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("s6_proto_err_reset", proto_err, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
